// File: rtl/bram_dump_reader.sv
// Sweeps a word-aligned region of a bram32 read port and streams each word with its byte address.
// Optional DUMP_CHECKSUM_EN adds a running mod-2^DATA_W sum of the accepted words.
module bram_dump_reader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_enb,
    input  logic [DATA_W-1:0] mem_dat,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_dat,
    output logic [ADDR_W-1:0] out_addr
`ifdef DUMP_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_SEND,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] dat;
    } beat_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cur_addr;
    logic [CNT_W-1:0]  remaining;
    beat_t             beat;
    logic              beat_vld;
    logic              accept;
    logic              hs;

    assign accept = (state == S_IDLE) && start;
    assign hs     = (state == S_SEND) && beat_vld && out_ready;

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        busy       = 1'b1;
        done       = 1'b0;
        mem_rd_enb = 1'b0;
        mem_addr   = '0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = (word_count != '0) ? S_ISSUE : S_DONE;
            end
            S_ISSUE: begin
                mem_rd_enb = 1'b1;
                mem_addr   = cur_addr;
                state_nxt  = S_CAPTURE;
            end
            S_CAPTURE: state_nxt = S_SEND;
            S_SEND: begin
                if (hs) state_nxt = (remaining == CNT_W'(1)) ? S_DONE : S_ISSUE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Word is held in beat until the consumer takes it; no new read is issued meanwhile.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_addr  <= '0;
            remaining <= '0;
            beat      <= '0;
            beat_vld  <= 1'b0;
        end else begin
            if (accept) begin
                cur_addr  <= {base_addr[ADDR_W-1:2], 2'b00};
                remaining <= word_count;
            end
            if (state == S_CAPTURE) begin
                beat.dat  <= mem_dat;
                beat.addr <= cur_addr;
                beat_vld  <= 1'b1;
            end
            if (hs) begin
                remaining <= remaining - CNT_W'(1);
                cur_addr  <= cur_addr + ADDR_W'(4);
                beat_vld  <= 1'b0;
            end
        end
    end

    assign out_valid = beat_vld;
    assign out_dat   = beat.dat;
    assign out_addr  = beat.addr;

`ifdef DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;

    always_ff @(posedge clk) begin
        if (!rst)        sum_q <= '0;
        else if (accept) sum_q <= '0;
        else if (hs)     sum_q <= sum_q + beat.dat;
    end

    assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_bram_dump_reader.sv
// Directed bench for bram_dump_reader with a 1-cycle-latency BRAM model behind the read port.
module tb_bram_dump_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  base_addr;
    logic [9:0]  word_count;
    logic        busy, done;
    logic [9:0]  mem_addr;
    logic        mem_rd_enb;
    logic [31:0] mem_dat;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_dat;
    logic [9:0]  out_addr;
`ifdef DUMP_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    bram_dump_reader #(.ADDR_W(10), .DATA_W(32), .CNT_W(10)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
        .busy(busy), .done(done), .mem_addr(mem_addr), .mem_rd_enb(mem_rd_enb), .mem_dat(mem_dat),
        .out_valid(out_valid), .out_ready(out_ready), .out_dat(out_dat), .out_addr(out_addr)
`ifdef DUMP_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:255];
    always @(posedge clk) if (mem_rd_enb) mem_dat <= mem[mem_addr[9:2]];

    int checks = 0;
    int errors = 0;
    logic [9:0]  q_addr[$];
    logic [31:0] q_dat[$];
    int first_valid, done_cyc, busy_cyc, rd_first, stall_bad, stall_rd, stall_seen;
    logic [31:0] hold_d;
    logic [9:0]  hold_a;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a dump and watches it cycle by cycle; c counts cycles after the accepting edge.
    task automatic run_dump(input logic [9:0] b, input logic [9:0] n, input int stall_beat,
                            input int stall_len, input bit restart);
        int stall_left;
        q_addr.delete();
        q_dat.delete();
        first_valid = -1; done_cyc = -1; busy_cyc = 0; rd_first = -1;
        stall_bad = 0; stall_rd = 0; stall_seen = 0;
        start = 1'b1; base_addr = b; word_count = n; out_ready = 1'b1;
        tick();
        start = 1'b0;
        stall_left = stall_len;
        for (int c = 1; c <= 80; c++) begin
            if (busy) busy_cyc++;
            if (mem_rd_enb && rd_first < 0) rd_first = c;
            if (out_valid && first_valid < 0) first_valid = c;
            if (restart && (c == 2 || c == 4)) begin
                start = 1'b1; word_count = 10'd7;
            end else start = 1'b0;
            out_ready = 1'b1;
            if (out_valid && q_addr.size() == stall_beat && stall_left > 0) begin
                if (stall_left == stall_len) begin
                    hold_d = out_dat; hold_a = out_addr;
                end else if (out_dat !== hold_d || out_addr !== hold_a) stall_bad++;
                if (mem_rd_enb) stall_rd++;
                stall_seen++;
                out_ready = 1'b0;
                stall_left--;
            end
            if (out_valid && out_ready) begin
                q_addr.push_back(out_addr);
                q_dat.push_back(out_dat);
            end
            if (done) begin
                done_cyc = c;
                break;
            end
            tick();
        end
        start = 1'b0; out_ready = 1'b1;
        tick();
    endtask

    task automatic check_beats(input string nm, input int n, input logic [9:0] ea[5],
                               input logic [31:0] ed[5]);
        checks++;
        if (q_addr.size() !== n) begin
            errors++;
            $display("FAIL %s beat_count got %0d exp %0d", nm, q_addr.size(), n);
        end
        for (int i = 0; i < n && i < q_addr.size(); i++) begin
            checks++;
            if (q_addr[i] !== ea[i] || q_dat[i] !== ed[i]) begin
                errors++;
                $display("FAIL %s beat%0d got (%h,%h) exp (%h,%h)", nm, i, q_addr[i], q_dat[i], ea[i], ed[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; base_addr = '0; word_count = '0; out_ready = 1'b1;
        tick(); tick();
        checks++;
        if ({busy, done, mem_rd_enb, out_valid} !== 4'b0 || mem_addr !== 10'h0 ||
            out_dat !== 32'h0 || out_addr !== 10'h0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b done=%b rd=%b vld=%b ma=%h od=%h oa=%h exp all 0",
                     busy, done, mem_rd_enb, out_valid, mem_addr, out_dat, out_addr);
        end
`ifdef DUMP_CHECKSUM_EN
        checks++;
        if (checksum !== 32'h0) begin
            errors++; $display("FAIL reset_checksum got %h exp 0", checksum);
        end
`endif
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [9:0]  ea[5] = '{10'h0, 10'h4, 10'h8, 10'hC, 10'h10};
        logic [31:0] ed[5] = '{32'h5, 32'h1, 32'h0, 32'h1, 32'hFFFFFFFF};
        run_dump(10'h0, 10'd5, -1, 0, 1'b0);
        check_beats("basic", 5, ea, ed);
        checks++;
        if (rd_first !== 1) begin errors++; $display("FAIL basic_rd_latency got %0d exp 1", rd_first); end
        checks++;
        if (first_valid !== 3) begin errors++; $display("FAIL basic_valid_latency got %0d exp 3", first_valid); end
        checks++;
        if (done_cyc !== 16) begin errors++; $display("FAIL basic_done_cycle got %0d exp 16", done_cyc); end
        checks++;
        if (busy_cyc !== 16) begin errors++; $display("FAIL basic_busy_cycles got %0d exp 16", busy_cyc); end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL basic_idle_after got busy=%b done=%b exp 0 0", busy, done);
        end
`ifdef DUMP_CHECKSUM_EN
        checks++;
        if (checksum !== 32'h6) begin errors++; $display("FAIL basic_checksum got %h exp 00000006", checksum); end
`endif
    endtask

    task automatic test_stall();
        logic [9:0]  ea[5] = '{10'h0, 10'h4, 10'h8, 10'hC, 10'h10};
        logic [31:0] ed[5] = '{32'h5, 32'h1, 32'h0, 32'h1, 32'hFFFFFFFF};
        run_dump(10'h0, 10'd5, 1, 4, 1'b0);
        check_beats("stall", 5, ea, ed);
        checks++;
        if (stall_seen !== 4 || hold_d !== 32'h1 || hold_a !== 10'h4) begin
            errors++;
            $display("FAIL stall_held got n=%0d d=%h a=%h exp n=4 d=00000001 a=004", stall_seen, hold_d, hold_a);
        end
        checks++;
        if (stall_bad !== 0) begin errors++; $display("FAIL stall_stable got %0d changes exp 0", stall_bad); end
        checks++;
        if (stall_rd !== 0) begin errors++; $display("FAIL stall_no_read got %0d reads exp 0", stall_rd); end
        checks++;
        if (done_cyc !== 20) begin errors++; $display("FAIL stall_done_cycle got %0d exp 20", done_cyc); end
    endtask

    task automatic test_wrap();
        logic [9:0]  ea[5] = '{10'h3F8, 10'h3FC, 10'h000, 10'h0, 10'h0};
        logic [31:0] ed[5] = '{32'h11111111, 32'h22222222, 32'h5, 32'h0, 32'h0};
        run_dump(10'h3FA, 10'd3, -1, 0, 1'b0);
        check_beats("wrap", 3, ea, ed);
        checks++;
        if (done_cyc !== 10) begin errors++; $display("FAIL wrap_done_cycle got %0d exp 10", done_cyc); end
`ifdef DUMP_CHECKSUM_EN
        checks++;
        if (checksum !== 32'h33333338) begin errors++; $display("FAIL wrap_checksum got %h exp 33333338", checksum); end
`endif
    endtask

    task automatic test_zero_count();
        run_dump(10'h10, 10'd0, -1, 0, 1'b0);
        checks++;
        if (first_valid !== -1 || q_addr.size() !== 0) begin
            errors++; $display("FAIL zero_no_beats got first_valid=%0d beats=%0d exp -1 0", first_valid, q_addr.size());
        end
        checks++;
        if (done_cyc !== 1) begin errors++; $display("FAIL zero_done_cycle got %0d exp 1", done_cyc); end
        checks++;
        if (busy_cyc !== 1 || rd_first !== -1) begin
            errors++; $display("FAIL zero_busy got busy_cycles=%0d rd_first=%0d exp 1 -1", busy_cyc, rd_first);
        end
`ifdef DUMP_CHECKSUM_EN
        checks++;
        if (checksum !== 32'h0) begin errors++; $display("FAIL zero_checksum got %h exp 0", checksum); end
`endif
    endtask

    task automatic test_reset_mid();
        logic [9:0]  ea[5] = '{10'h8, 10'h0, 10'h0, 10'h0, 10'h0};
        logic [31:0] ed[5] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        int nb = 0;
        bit found = 1'b0;
        int bad = 0;
        start = 1'b1; base_addr = 10'h0; word_count = 10'd5; out_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid) begin
                if (nb == 2) begin found = 1'b1; break; end
                nb++;
            end
            tick();
        end
        checks++;
        if (!found) begin errors++; $display("FAIL rstmid_reach_beat3 got beats=%0d exp 2 before third", nb); end
        rst = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_dat !== 32'h0 || out_addr !== 10'h0) begin
            errors++;
            $display("FAIL rstmid_abort got vld=%b busy=%b done=%b od=%h oa=%h exp 0", out_valid, busy, done, out_dat, out_addr);
        end
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (done || out_valid || busy) bad++;
            tick();
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL rstmid_quiet got %0d active cycles exp 0", bad); end
        run_dump(10'h8, 10'd1, -1, 0, 1'b0);
        check_beats("rstmid_redump", 1, ea, ed);
        checks++;
        if (done_cyc !== 4) begin errors++; $display("FAIL rstmid_redump_done got %0d exp 4", done_cyc); end
    endtask

    task automatic test_start_busy();
        logic [9:0]  ea[5] = '{10'h0, 10'h4, 10'h8, 10'h0, 10'h0};
        logic [31:0] ed[5] = '{32'h5, 32'h1, 32'h0, 32'h0, 32'h0};
        run_dump(10'h0, 10'd3, -1, 0, 1'b1);
        check_beats("start_busy", 3, ea, ed);
        checks++;
        if (done_cyc !== 10) begin errors++; $display("FAIL start_busy_done got %0d exp 10", done_cyc); end
`ifdef DUMP_CHECKSUM_EN
        checks++;
        if (checksum !== 32'h6) begin errors++; $display("FAIL start_busy_checksum got %h exp 00000006", checksum); end
`endif
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA5000000 | i;
        mem[0] = 32'h5; mem[1] = 32'h1; mem[2] = 32'h0; mem[3] = 32'h1; mem[4] = 32'hFFFFFFFF;
        mem[254] = 32'h11111111; mem[255] = 32'h22222222;
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_zero_count();
        test_reset_mid();
        test_start_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
